// File: rtl/bcd_pkg.sv
// Shared types and constants for the serial packed-BCD adder.
package bcd_pkg;

    typedef enum logic [1:0] {IDLE, ADD, CORR, DONE} state_t;

    localparam logic [3:0] BCD_MAX = 4'd9;
    localparam logic [3:0] BCD_FIX = 4'd6;

    function automatic logic digit_invalid(input logic [3:0] d);
        return d > BCD_MAX;
    endfunction

endpackage

// File: rtl/binary_adder_4bit.sv
// Plain 4-bit ripple-carry binary adder used as the shared datapath.
module binary_adder_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [4:0] carry;

    always_comb begin
        carry    = '0;
        sum      = '0;
        carry[0] = cin;
        for (int i = 0; i < 4; i++) begin
            sum[i]       = a[i] ^ b[i] ^ carry[i];
            carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
        end
        cout = carry[4];
    end

endmodule

// File: rtl/bcd_serial_adder_ctrl.sv
// Digit-serial packed-BCD adder: one binary pass and one decimal-correction
// pass per digit through a single shared 4-bit adder, LSD first.
module bcd_serial_adder_ctrl
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   a,
    input  logic [4*DIGITS-1:0]   b,
    input  logic                  c_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   sum,
    output logic                  c_out,
    output logic                  err
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

    state_t              state, next_state;
    logic [4*DIGITS-1:0] a_reg, b_reg;
    logic [IDX_W-1:0]    idx;
    logic                carry;
    logic [3:0]          raw;
    logic                k;

    logic [3:0] add_a, add_b, add_sum;
    logic       add_cin, add_cout;
    logic       fix;
    logic       any_bad;

    binary_adder_4bit u_adder (
        .a    (add_a),
        .b    (add_b),
        .cin  (add_cin),
        .sum  (add_sum),
        .cout (add_cout)
    );

    always_comb begin
        any_bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (digit_invalid(a[4*i +: 4]) || digit_invalid(b[4*i +: 4]))
                any_bad = 1'b1;
        end
    end

    // Operand muxes: ADD feeds the operand digits, CORR feeds raw plus 6 or 0.
    always_comb begin
        next_state = state;
        add_a      = 4'd0;
        add_b      = 4'd0;
        add_cin    = 1'b0;
        fix        = k | (raw > BCD_MAX);
        case (state)
            IDLE: if (start) next_state = ADD;
            ADD: begin
                add_a      = a_reg[4*idx +: 4];
                add_b      = b_reg[4*idx +: 4];
                add_cin    = carry;
                next_state = CORR;
            end
            CORR: begin
                add_a      = raw;
                add_b      = fix ? BCD_FIX : 4'd0;
                next_state = (idx == LAST_IDX) ? DONE : ADD;
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            a_reg <= '0;
            b_reg <= '0;
            idx   <= '0;
            carry <= 1'b0;
            raw   <= 4'd0;
            k     <= 1'b0;
            sum   <= '0;
            c_out <= 1'b0;
            err   <= 1'b0;
        end else begin
            state <= next_state;
            case (state)
                IDLE: if (start) begin
                    a_reg <= a;
                    b_reg <= b;
                    carry <= c_in;
                    idx   <= '0;
                    sum   <= '0;
                    c_out <= 1'b0;
                    err   <= any_bad;
                end
                ADD: begin
                    raw <= add_sum;
                    k   <= add_cout;
                end
                // c_out is loaded on the edge into DONE so it is valid with done.
                CORR: begin
                    sum[4*idx +: 4] <= add_sum;
                    carry           <= fix;
                    if (idx == LAST_IDX) c_out <= fix;
                    else                 idx   <= idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy = (state == ADD) || (state == CORR);
    assign done = (state == DONE);

endmodule

// File: tb/tb_bcd_serial_adder_ctrl.sv
// Randomized self-checking bench against a decimal-arithmetic reference model.
module tb_bcd_serial_adder_ctrl;

    localparam int DIGITS = 4;
    localparam int W      = 4 * DIGITS;
    localparam int MODV   = 10 ** DIGITS;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a, b;
    logic         c_in;
    logic         busy, done, c_out, err;
    logic [W-1:0] sum;

    int n_checks = 0;
    int n_pass   = 0;

    bcd_serial_adder_ctrl #(.DIGITS(DIGITS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .c_in  (c_in),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .c_out (c_out),
        .err   (err)
    );

    always #5 clk = ~clk;

    function automatic bit has_bad(input logic [W-1:0] v);
        for (int i = 0; i < DIGITS; i++)
            if (v[4*i +: 4] > 4'd9) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int bcd_to_int(input logic [W-1:0] v);
        int r = 0;
        for (int i = DIGITS - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
        return r;
    endfunction

    function automatic logic [W-1:0] int_to_bcd(input int n);
        logic [W-1:0] r = '0;
        int m = n;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(m % 10);
            m = m / 10;
        end
        return r;
    endfunction

    function automatic logic [W-1:0] rand_bcd();
        logic [W-1:0] r = '0;
        for (int i = 0; i < DIGITS; i++) r[4*i +: 4] = 4'($urandom_range(0, 9));
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Runs one addition from acceptance to the cycle after done; optionally
    // pokes start mid-operation and during done to prove it is ignored.
    task automatic applyStimulus(input logic [W-1:0] op_a, input logic [W-1:0] op_b,
                                 input logic cin, input bit poke);
        int  total, cyc;
        bit  bad;
        bad   = has_bad(op_a) || has_bad(op_b);
        total = bad ? 0 : bcd_to_int(op_a) + bcd_to_int(op_b) + int'(cin);
        a = op_a; b = op_b; c_in = cin; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        cyc   = 1;
        checkOutput("busy_after_accept", 32'(busy), 32'd1);
        while (!done && cyc < 20) begin
            if (poke && cyc == 4) begin
                start = 1'b1; a = rand_bcd(); b = rand_bcd(); c_in = ~cin;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        checkOutput("latency", 32'(cyc), 32'd9);
        checkOutput("busy_at_done", 32'(busy), 32'd0);
        checkOutput("err", 32'(err), 32'(bad));
        if (!bad) begin
            checkOutput("sum", 32'(sum), 32'(int_to_bcd(total % MODV)));
            checkOutput("c_out", 32'(c_out), 32'(total >= MODV));
        end
        start = poke ? 1'b1 : 1'b0;
        @(negedge clk);
        start = 1'b0;
        checkOutput("done_pulse_width", 32'(done), 32'd0);
        checkOutput("idle_after_done", 32'(busy), 32'd0);
    endtask

    initial begin
        int done_seen;
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; c_in = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_sum", 32'(sum), 32'd0);
        checkOutput("rst_c_out", 32'(c_out), 32'd0);
        checkOutput("rst_err", 32'(err), 32'd0);

        applyStimulus(16'h1234, 16'h5678, 1'b0, 1'b0);
        applyStimulus(16'h9999, 16'h0001, 1'b0, 1'b0);
        applyStimulus(16'h9999, 16'h9999, 1'b1, 1'b0);
        applyStimulus(16'h0009, 16'h0009, 1'b1, 1'b0);
        applyStimulus(16'h00A0, 16'h0000, 1'b0, 1'b0);
        applyStimulus(16'h4821, 16'h3907, 1'b1, 1'b1);

        // Abort an operation with reset in its fifth cycle.
        a = 16'h12A4; b = 16'h5678; c_in = 1'b1; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_sum", 32'(sum), 32'd0);
        checkOutput("abort_err", 32'(err), 32'd0);
        checkOutput("abort_c_out", 32'(c_out), 32'd0);
        done_seen = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        checkOutput("abort_no_done", 32'(done_seen), 32'd0);

        applyStimulus(16'h1234, 16'h5678, 1'b0, 1'b0);

        for (int n = 0; n < 30; n++) begin
            logic [W-1:0] ra, rb;
            ra = rand_bcd();
            rb = rand_bcd();
            if ($urandom_range(0, 9) == 0) ra[4*$urandom_range(0, DIGITS-1) +: 4] = 4'($urandom_range(10, 15));
            applyStimulus(ra, rb, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/bcd_serial_adder_ctrl.md
Name: bcd_serial_adder_ctrl

Overview:
Sequencer that adds two multi-digit packed-BCD operands by time-sharing one internal 4-bit binary ripple adder, one digit per step, LSD first.
- Each digit takes two adder passes: a binary add, then a decimal correction of +6 or +0.
- Sits between a request source (start/operands) and any consumer of a registered BCD sum with a done pulse.

Parameters:
DIGITS, 4, number of BCD digits per operand (1..8)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request; accepted only when busy=0
a  input  4*DIGITS  packed-BCD operand A, digit 0 in bits [3:0]
b  input  4*DIGITS  packed-BCD operand B
c_in  input  1  decimal carry into digit 0
busy  output  1  high from the cycle after acceptance until done
done  output  1  one-cycle pulse, sum/c_out/err valid
sum  output  4*DIGITS  packed-BCD result, held until next acceptance
c_out  output  1  decimal carry out of the MSD
err  output  1  any operand digit >9 at acceptance; held with sum

Behaviour:
- Reset (async assert, sync release): state=IDLE; busy, done, sum, c_out, err all 0; internal digit index, carry and raw registers 0.
- Acceptance: start=1 while state=IDLE.
  - Registers a, b, c_in.
  - Computes err = any 4-bit digit of a or b >9.
  - Clears sum; index=0; carry=c_in; goes to ADD.
- start while busy=1 or while done=1 is ignored and has no side effects.
- FSM states: IDLE, ADD, CORR, DONE.
- ADD (digit i):
  - Adder inputs are a_i, b_i and carry.
  - Registers raw = adder sum (4 bits) and k = adder carry-out.
  - Goes to CORR.
- CORR (digit i):
  - fix = k | (raw > 9).
  - Adder inputs are raw, fix ? 4'd6 : 4'd0, and cin 0.
  - sum digit i = adder sum, taking only 4 bits; the adder carry-out is discarded.
  - carry = fix.
  - If i == DIGITS-1, goes to DONE; else i = i+1 and goes to ADD.
- DONE:
  - done=1 and busy=0 for exactly one cycle.
  - c_out = carry.
  - Goes to IDLE.
- busy is 1 in the ADD and CORR states only.
- Fixed latency: acceptance at edge T gives the done pulse in cycle T+2*DIGITS+1. For DIGITS=4 that is 9 cycles after acceptance.
- Back-to-back operation: a new start is accepted in the IDLE cycle that follows DONE. Minimum issue interval is 2*DIGITS+2 cycles.
- Invalid digits:
  - The arithmetic still runs with the same algorithm.
  - The result is unspecified as BCD; only err=1 is guaranteed.
- Reset during ADD/CORR aborts the operation, clears all outputs and produces no done pulse.
- Max case per digit: 9+9+1 = 19, raw=0011, k=1, corrected digit 9, carry 1. The correction never overflows 4 bits in a meaningful way.

Decomposition:
- Shared package bcd_pkg holds:
  - state enum {IDLE, ADD, CORR, DONE};
  - constant BCD_MAX = 4'd9;
  - constant BCD_FIX = 4'd6.
- One sub-module is natural: a single instance of binary_adder_4bit as the shared datapath. Its operand muxes, selected by state, live in this block.
- No other sub-modules.

Test Plan:
- Reset held, then released, with start=0 → busy=0, done=0, sum=0, c_out=0, err=0.
- a=0x1234, b=0x5678, c_in=0 → done exactly 9 cycles after acceptance; sum=0x6912, c_out=0, err=0.
- a=0x9999, b=0x0001, c_in=0 → sum=0x0000, c_out=1; repeat with b=0x9999, c_in=1 → sum=0x9999, c_out=1.
- a=0x0009, b=0x0009, c_in=1 → sum=0x0019, c_out=0.
- a=0x00A0, b=0x0000 → err=1 at done; done still arrives on cycle 9.
- Second start pulsed mid-operation → ignored, first result unchanged. rst_n asserted in cycle 5 → outputs 0 immediately and no done pulse. A start accepted after reset gives the correct result 9 cycles later.
